// File: rtl/adc_data_path.sv
// Six-stream ADC capture into AXI4 write bursts through a dual-beat-push FIFO.
// Optional ADC_DATA_PATH_RUN_CNT_EN adds a capture-duration counter on run_cycles.
module adc_data_path #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic         ps_clk,
  input  logic         ps_rstb,
  input  logic [127:0] s_axis0_tdata,
  input  logic         s_axis0_tvalid,
  output logic         s_axis0_tready,
  input  logic [127:0] s_axis1_tdata,
  input  logic         s_axis1_tvalid,
  output logic         s_axis1_tready,
  input  logic [127:0] s_axis2_tdata,
  input  logic         s_axis2_tvalid,
  output logic         s_axis2_tready,
  input  logic [127:0] s_axis3_tdata,
  input  logic         s_axis3_tvalid,
  output logic         s_axis3_tready,
  input  logic [127:0] s_axis4_tdata,
  input  logic         s_axis4_tvalid,
  output logic         s_axis4_tready,
  input  logic [127:0] s_axis5_tdata,
  input  logic         s_axis5_tvalid,
  output logic         s_axis5_tready,
  output logic [3:0]   m_axi_awid,
  output logic [31:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  output logic [1:0]   m_axi_awburst,
  output logic         m_axi_awlock,
  output logic [3:0]   m_axi_awcache,
  output logic [2:0]   m_axi_awprot,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [127:0] m_axi_wdata,
  output logic [15:0]  m_axi_wstrb,
  output logic         m_axi_wlast,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [3:0]   m_axi_bid,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  output logic         m_axi_arvalid,
  output logic         m_axi_rready,
  input  logic         write_start,
  input  logic         write_reset,
  input  logic [31:0]  start_address,
  input  logic [31:0]  cap_size,
  output logic [31:0]  datamover_status,
  output logic [31:0]  current_addr,
  output logic [31:0]  run_cycles,
  output logic         wr_mm2s_err,
  output logic         cap_done
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t        state;
  logic          start_q;
  logic [127:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [31:0]   target, pushed, remaining, addr;
  logic          outstanding, overflow, err;
  logic [1:0]    bresp_l;
  logic [8:0]    w_left, len, to_4k;
  logic          start_rise, sample, push, drop, pop, issue, b_hs, busy;
  logic [31:0]   start_beats;
  logic [127:0]  beat_a, beat_b;
  logic          unused;

  assign start_rise  = write_start & ~start_q;
  assign start_beats = {4'b0, cap_size[31:5], 1'b0};
  assign busy        = (state == CAPTURE) || (state == DRAIN);
  assign sample      = (state == CAPTURE) && s_axis0_tvalid && s_axis1_tvalid && s_axis2_tvalid
                       && s_axis3_tvalid && s_axis4_tvalid && s_axis5_tvalid;
  assign push        = sample && ((32'(count) + 32'd2) <= FIFO_DEPTH);
  assign drop        = sample && !push;
  assign pop         = m_axi_wvalid && m_axi_wready;
  assign b_hs        = outstanding && m_axi_bvalid;
  assign beat_a      = {s_axis3_tdata[31:0], s_axis2_tdata[31:0], s_axis1_tdata[31:0], s_axis0_tdata[31:0]};
  assign beat_b      = {64'h0, s_axis5_tdata[31:0], s_axis4_tdata[31:0]};

  assign s_axis0_tready = ps_rstb & ~write_reset;
  assign s_axis1_tready = ps_rstb & ~write_reset;
  assign s_axis2_tready = ps_rstb & ~write_reset;
  assign s_axis3_tready = ps_rstb & ~write_reset;
  assign s_axis4_tready = ps_rstb & ~write_reset;
  assign s_axis5_tready = ps_rstb & ~write_reset;

  assign m_axi_awid    = '0;
  assign m_axi_awsize  = 3'b100;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = 1'b1;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
  assign m_axi_wdata   = mem[rp];
  assign m_axi_wlast   = m_axi_wvalid && (w_left == 9'd1);

  assign datamover_status = {28'b0, bresp_l, overflow, busy};
  assign current_addr     = addr;
  assign wr_mm2s_err      = err;
  assign cap_done         = (state == DONE);

  assign unused = ^{m_axi_bid, start_address[3:0], cap_size[4:0],
                    s_axis0_tdata[127:32], s_axis1_tdata[127:32], s_axis2_tdata[127:32],
                    s_axis3_tdata[127:32], s_axis4_tdata[127:32], s_axis5_tdata[127:32]};

  // Burst length: bounded by MAX_BURST, beats still owed, and the next 4 KB boundary.
  always_comb begin
    to_4k = 9'd256 - {1'b0, addr[11:4]};
    len   = 9'(MAX_BURST);
    if (remaining < 32'(len)) len = remaining[8:0];
    if (to_4k < len) len = to_4k;
  end

  assign issue = busy && !outstanding && (remaining != '0) && (32'(count) >= 32'(len));

  // Both beats of a sample land in one cycle; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge ps_clk) begin
    if (push) begin
      mem[wp]          <= beat_a;
      mem[wp + PW'(1)] <= beat_b;
    end
  end

  always_ff @(posedge ps_clk or negedge ps_rstb) begin
    if (!ps_rstb) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      wp            <= '0;
      rp            <= '0;
      count         <= '0;
      target        <= '0;
      pushed        <= '0;
      remaining     <= '0;
      addr          <= '0;
      outstanding   <= 1'b0;
      overflow      <= 1'b0;
      err           <= 1'b0;
      bresp_l       <= '0;
      w_left        <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_wvalid  <= 1'b0;
    end else begin
      start_q <= write_start;
      if (write_reset) begin
        state         <= IDLE;
        wp            <= '0;
        rp            <= '0;
        count         <= '0;
        target        <= '0;
        pushed        <= '0;
        remaining     <= '0;
        addr          <= '0;
        outstanding   <= 1'b0;
        overflow      <= 1'b0;
        err           <= 1'b0;
        bresp_l       <= '0;
        w_left        <= '0;
        m_axi_awvalid <= 1'b0;
        m_axi_awaddr  <= '0;
        m_axi_awlen   <= '0;
        m_axi_wvalid  <= 1'b0;
      end else begin
        count <= count + (push ? CW'(2) : CW'(0)) - (pop ? CW'(1) : CW'(0));
        if (push) wp <= wp + PW'(2);
        if (pop)  rp <= rp + PW'(1);
        // Dropped samples shrink the AXI workload so draining never waits on missing data.
        remaining <= remaining - (issue ? 32'(len) : 32'd0) - (drop ? 32'd2 : 32'd0);
        if (drop) begin
          overflow <= 1'b1;
          err      <= 1'b1;
        end
        if (issue) begin
          m_axi_awvalid <= 1'b1;
          m_axi_awaddr  <= addr;
          m_axi_awlen   <= 8'(len - 9'd1);
          m_axi_wvalid  <= 1'b1;
          w_left        <= len;
          outstanding   <= 1'b1;
        end
        if (m_axi_awvalid && m_axi_awready) begin
          m_axi_awvalid <= 1'b0;
          addr          <= addr + (({24'b0, m_axi_awlen} + 32'd1) << 4);
        end
        if (pop) begin
          w_left <= w_left - 9'd1;
          if (w_left == 9'd1) m_axi_wvalid <= 1'b0;
        end
        if (b_hs) begin
          outstanding <= 1'b0;
          if (m_axi_bresp != 2'b00) begin
            err     <= 1'b1;
            bresp_l <= m_axi_bresp;
          end
        end
        case (state)
          IDLE, DONE: begin
            if (start_rise) begin
              addr      <= {start_address[31:4], 4'b0};
              target    <= start_beats;
              remaining <= start_beats;
              pushed    <= '0;
              state     <= (cap_size[31:5] == '0) ? DONE : CAPTURE;
            end
          end
          CAPTURE: begin
            if (sample) begin
              pushed <= pushed + 32'd2;
              if (pushed + 32'd2 == target) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (remaining == '0 && !outstanding) state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ADC_DATA_PATH_RUN_CNT_EN
  logic [31:0] run_cnt;

  always_ff @(posedge ps_clk or negedge ps_rstb) begin
    if (!ps_rstb) begin
      run_cnt <= '0;
    end else if (write_reset) begin
      run_cnt <= '0;
    end else if ((state == IDLE || state == DONE) && start_rise) begin
      run_cnt <= '0;
    end else if (busy) begin
      run_cnt <= run_cnt + 32'd1;
    end
  end

  assign run_cycles = run_cnt;
`else
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_adc_data_path.sv
// Self-checking bench for adc_data_path: random ADC stimulus, AXI write slave model,
// and a spec-level reference of expected beats, bursts and addresses.
module tb_adc_data_path;

  localparam int MAXB = 16;
  localparam logic [16:0] FIXED_EXP = {4'h0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'b000};

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic [127:0] tdata [6];
  logic [5:0]   tvalid;
  wire  [5:0]   tready;

  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic         awvalid, awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready, arvalid, rready;
  logic         write_start, write_reset;
  logic [31:0]  start_address, cap_size;
  logic [31:0]  datamover_status, current_addr, run_cycles;
  logic         wr_mm2s_err, cap_done;

  adc_data_path #(.FIFO_DEPTH(64), .MAX_BURST(MAXB)) dut (
    .ps_clk(clk), .ps_rstb(rstb),
    .s_axis0_tdata(tdata[0]), .s_axis0_tvalid(tvalid[0]), .s_axis0_tready(tready[0]),
    .s_axis1_tdata(tdata[1]), .s_axis1_tvalid(tvalid[1]), .s_axis1_tready(tready[1]),
    .s_axis2_tdata(tdata[2]), .s_axis2_tvalid(tvalid[2]), .s_axis2_tready(tready[2]),
    .s_axis3_tdata(tdata[3]), .s_axis3_tvalid(tvalid[3]), .s_axis3_tready(tready[3]),
    .s_axis4_tdata(tdata[4]), .s_axis4_tvalid(tvalid[4]), .s_axis4_tready(tready[4]),
    .s_axis5_tdata(tdata[5]), .s_axis5_tvalid(tvalid[5]), .s_axis5_tready(tready[5]),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(4'h0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_rready(rready),
    .write_start(write_start), .write_reset(write_reset),
    .start_address(start_address), .cap_size(cap_size),
    .datamover_status(datamover_status), .current_addr(current_addr),
    .run_cycles(run_cycles), .wr_mm2s_err(wr_mm2s_err), .cap_done(cap_done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [16:0] fixed;
  } aw_t;

  int compared = 0;
  int mismatched = 0;

  aw_t          aw_q[$];
  logic [127:0] w_data_q[$];
  logic         w_last_q[$];
  logic [127:0] exp_q[$];
  logic [31:0]  exp_aw_addr[$];
  int           exp_aw_len[$];
  logic         exp_last[$];
  logic [31:0]  exp_end_addr;

  int ready_pct = 100;
  bit w_stall = 0;
  int b_owed = 0;
  int b_index = 0;
  int err_idx = -1;
  int strb_bad = 0;

  // AXI write slave: ready/response decisions at negedge, transfers logged for the next posedge.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (bvalid) begin
        bvalid = 0;
      end else if (b_owed > 0 && $urandom_range(0, 2) == 0) begin
        bvalid = 1;
        bresp = (b_index == err_idx) ? 2'b10 : 2'b00;
        b_index++;
        b_owed--;
      end
      awready = ($urandom_range(0, 99) < ready_pct);
      wready = !w_stall && ($urandom_range(0, 99) < ready_pct);
      if (awvalid && awready)
        aw_q.push_back('{addr: awaddr, len: awlen,
                         fixed: {awid, awsize, awburst, awlock, awcache, awprot}});
      if (wvalid && wready) begin
        w_data_q.push_back(wdata);
        w_last_q.push_back(wlast);
        if (wstrb !== 16'hFFFF) strb_bad++;
        if (wlast) b_owed++;
      end
    end
  end

  // Reference burst plan from the address/length rules: min(MAX_BURST, remaining, to 4 KB).
  function automatic void model_bursts(input logic [31:0] sa, input int beats);
    longint a = longint'(sa & 32'hFFFF_FFF0);
    int rem = beats;
    int l;
    exp_aw_addr.delete(); exp_aw_len.delete(); exp_last.delete();
    while (rem > 0) begin
      l = MAXB;
      if (rem < l) l = rem;
      if (int'((4096 - (a % 4096)) / 16) < l) l = int'((4096 - (a % 4096)) / 16);
      exp_aw_addr.push_back(32'(a));
      exp_aw_len.push_back(l);
      for (int j = 0; j < l; j++) exp_last.push_back(j == l - 1);
      a += 16 * l;
      rem -= l;
    end
    exp_end_addr = 32'(a);
  endfunction

  task automatic soft_reset();
    @(negedge clk); write_reset = 1;
    @(negedge clk); write_reset = 0;
  endtask

  task automatic drive_sample(input int pct, output bit took);
    logic [5:0] v;
    for (int k = 0; k < 6; k++) tdata[k] = {$urandom, $urandom, $urandom, $urandom};
    took = ($urandom_range(0, 99) < pct);
    v = took ? 6'h3F : 6'($urandom_range(0, 62));
    tvalid = v;
    if (took) begin
      exp_q.push_back({tdata[3][31:0], tdata[2][31:0], tdata[1][31:0], tdata[0][31:0]});
      exp_q.push_back({64'h0, tdata[5][31:0], tdata[4][31:0]});
    end
  endtask

  task automatic run_capture(input logic [31:0] sa, input logic [31:0] cs, input int pct,
                             input int stall, input bit mid_start, output bit timed_out);
    int nsamp = int'(cs >> 5);
    int done_s = 0;
    int cycles = 0;
    bit took;
    bit pulsed = 0;
    exp_q.delete(); aw_q.delete(); w_data_q.delete(); w_last_q.delete();
    timed_out = 0;
    @(negedge clk);
    start_address = sa; cap_size = cs; write_start = 1; tvalid = '0;
    @(negedge clk);
    write_start = 0;
    w_stall = (stall > 0);
    while (1) begin
      write_start = 0;
      if (mid_start && !pulsed && done_s == nsamp / 2) begin
        write_start = 1;
        pulsed = 1;
      end
      if (done_s < nsamp) begin
        drive_sample(pct, took);
        if (took) done_s++;
      end else begin
        tvalid = '0;
      end
      if (cycles >= stall) w_stall = 0;
      @(negedge clk);
      cycles++;
      if (cap_done) break;
      if (cycles > 30000) begin
        timed_out = 1;
        break;
      end
    end
    tvalid = '0; w_stall = 0; write_start = 0;
  endtask

  task automatic test_reset();
    rstb = 1;
    #3 rstb = 0;
    @(negedge clk); @(negedge clk);
    compared++;
    if (tready !== 6'h00) begin $display("FAIL reset_tready got=%h want=00", tready); mismatched++; end
    compared++;
    if ({awvalid, wvalid, arvalid, rready} !== 4'b0000) begin
      $display("FAIL reset_valids got=%b want=0000", {awvalid, wvalid, arvalid, rready}); mismatched++;
    end
    compared++;
    if ({datamover_status, current_addr, run_cycles} !== 96'h0) begin
      $display("FAIL reset_status got=%h/%h/%h want=0", datamover_status, current_addr, run_cycles); mismatched++;
    end
    compared++;
    if ({wr_mm2s_err, cap_done} !== 2'b00) begin
      $display("FAIL reset_flags got=%b want=00", {wr_mm2s_err, cap_done}); mismatched++;
    end
    rstb = 1;
    @(negedge clk);
    compared++;
    if (tready !== 6'h3F || bready !== 1'b1) begin
      $display("FAIL post_reset_ready got=%h/%b want=3f/1", tready, bready); mismatched++;
    end
  endtask

  task automatic test_basic();
    bit to;
    ready_pct = 100;
    run_capture(32'h0, 32'd320, 100, 0, 1, to);
    model_bursts(32'h0, 20);
    compared++;
    if (to) begin $display("FAIL basic_timeout cap_done never rose"); mismatched++; end
    compared++;
    if (aw_q.size() !== exp_aw_addr.size()) begin
      $display("FAIL basic_aw_count got=%0d want=%0d", aw_q.size(), exp_aw_addr.size()); mismatched++;
    end else begin
      foreach (aw_q[i]) begin
        compared++;
        if (aw_q[i].addr !== exp_aw_addr[i] || aw_q[i].len !== 8'(exp_aw_len[i] - 1)) begin
          $display("FAIL basic_aw[%0d] got=%h/%0d want=%h/%0d", i, aw_q[i].addr, aw_q[i].len,
                   exp_aw_addr[i], exp_aw_len[i] - 1);
          mismatched++;
        end
      end
      compared++;
      if (aw_q[0].fixed !== FIXED_EXP) begin
        $display("FAIL basic_aw_fixed got=%h want=%h", aw_q[0].fixed, FIXED_EXP); mismatched++;
      end
    end
    compared++;
    if (w_data_q.size() !== exp_q.size()) begin
      $display("FAIL basic_w_count got=%0d want=%0d", w_data_q.size(), exp_q.size()); mismatched++;
    end else begin
      foreach (exp_q[i]) begin
        compared++;
        if (w_data_q[i] !== exp_q[i] || w_last_q[i] !== exp_last[i]) begin
          $display("FAIL basic_w[%0d] got=%h/%b want=%h/%b", i, w_data_q[i], w_last_q[i],
                   exp_q[i], exp_last[i]);
          mismatched++;
          break;
        end
      end
    end
    compared++;
    if (current_addr !== 32'h140 || datamover_status !== 32'h0 || wr_mm2s_err !== 1'b0) begin
      $display("FAIL basic_end got=%h/%h/%b want=140/0/0", current_addr, datamover_status, wr_mm2s_err);
      mismatched++;
    end
    compared++;
    if (strb_bad !== 0) begin $display("FAIL basic_wstrb got=%0d bad want=0", strb_bad); mismatched++; end
    compared++;
`ifdef ADC_DATA_PATH_RUN_CNT_EN
    if (run_cycles < 32'd20) begin $display("FAIL basic_run_cycles got=%0d want>=20", run_cycles); mismatched++; end
`else
    if (run_cycles !== 32'h0) begin $display("FAIL basic_run_cycles got=%0d want=0", run_cycles); mismatched++; end
`endif
  endtask

  task automatic test_4k_boundary();
    bit to;
    ready_pct = 70;
    run_capture(32'h0000_0FC5, 32'd256, 70, 0, 0, to);
    model_bursts(32'h0000_0FC5, 16);
    compared++;
    if (to || aw_q.size() !== 2) begin
      $display("FAIL 4k_aw_count got=%0d timeout=%b want=2", aw_q.size(), to); mismatched++;
    end else begin
      compared++;
      if (aw_q[0].addr !== 32'hFC0 || aw_q[0].len !== 8'd3 || aw_q[1].addr !== 32'h1000 || aw_q[1].len !== 8'd11) begin
        $display("FAIL 4k_bursts got=%h/%0d %h/%0d want=fc0/3 1000/11", aw_q[0].addr, aw_q[0].len,
                 aw_q[1].addr, aw_q[1].len);
        mismatched++;
      end
    end
    compared++;
    if (current_addr !== 32'h10C0) begin $display("FAIL 4k_addr got=%h want=10c0", current_addr); mismatched++; end
    compared++;
    if (w_data_q != exp_q || w_last_q != exp_last) begin
      $display("FAIL 4k_data got=%0d beats want=%0d beats (or content/wlast differs)", w_data_q.size(), exp_q.size());
      mismatched++;
    end
  endtask

  task automatic test_small_cap();
    bit to;
    run_capture(32'h0000_0104, 32'd31, 100, 0, 0, to);
    repeat (20) @(negedge clk);
    compared++;
    if (cap_done !== 1'b1 || datamover_status[0] !== 1'b0) begin
      $display("FAIL small_done got=%b busy=%b want=1/0", cap_done, datamover_status[0]); mismatched++;
    end
    compared++;
    if (aw_q.size() !== 0 || w_data_q.size() !== 0) begin
      $display("FAIL small_traffic got=%0d aw %0d w want=0/0", aw_q.size(), w_data_q.size()); mismatched++;
    end
    compared++;
    if (current_addr !== 32'h100) begin $display("FAIL small_addr got=%h want=100", current_addr); mismatched++; end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [31:0] sa, cs;
    for (int it = 0; it < 5; it++) begin
      sa = $urandom_range(0, 32'h3FFF);
      cs = $urandom_range(32, 1600);
      ready_pct = $urandom_range(40, 100);
      run_capture(sa, cs, $urandom_range(30, 100), 0, 0, to);
      model_bursts(sa, int'(cs >> 5) * 2);
      compared++;
      if (to) begin $display("FAIL b2b_timeout iter=%0d", it); mismatched++; end
      compared++;
      if (aw_q.size() !== exp_aw_addr.size()) begin
        $display("FAIL b2b_aw_count iter=%0d got=%0d want=%0d", it, aw_q.size(), exp_aw_addr.size()); mismatched++;
      end else begin
        foreach (aw_q[i]) begin
          compared++;
          if (aw_q[i].addr !== exp_aw_addr[i] || aw_q[i].len !== 8'(exp_aw_len[i] - 1)) begin
            $display("FAIL b2b_aw iter=%0d idx=%0d got=%h/%0d want=%h/%0d", it, i, aw_q[i].addr,
                     aw_q[i].len, exp_aw_addr[i], exp_aw_len[i] - 1);
            mismatched++;
            break;
          end
        end
      end
      compared++;
      if (w_data_q != exp_q || w_last_q != exp_last) begin
        $display("FAIL b2b_data iter=%0d got=%0d beats want=%0d beats (or content/wlast differs)", it,
                 w_data_q.size(), exp_q.size());
        mismatched++;
      end
      compared++;
      if (current_addr !== exp_end_addr) begin
        $display("FAIL b2b_addr iter=%0d got=%h want=%h", it, current_addr, exp_end_addr); mismatched++;
      end
    end
  endtask

  task automatic test_overflow();
    bit to;
    logic [127:0] kept[$];
    soft_reset();
    ready_pct = 100;
    run_capture(32'h0, 32'd4096, 100, 300, 0, to);
    compared++;
    if (to || cap_done !== 1'b1) begin $display("FAIL ovf_done got=%b timeout=%b want=1", cap_done, to); mismatched++; end
    compared++;
    if (datamover_status[1] !== 1'b1 || wr_mm2s_err !== 1'b1) begin
      $display("FAIL ovf_flags got=%b/%b want=1/1", datamover_status[1], wr_mm2s_err); mismatched++;
    end
    // With W fully stalled the 64-beat buffer keeps exactly the first 32 samples.
    kept = exp_q[0:63];
    compared++;
    if (w_data_q != kept) begin
      $display("FAIL ovf_data got=%0d beats want=64 beats (or content differs)", w_data_q.size()); mismatched++;
    end
    compared++;
    if (current_addr !== 32'h400) begin $display("FAIL ovf_addr got=%h want=400", current_addr); mismatched++; end
  endtask

  task automatic test_bresp_err();
    bit to;
    soft_reset();
    b_index = 0;
    err_idx = 0;
    ready_pct = 80;
    run_capture(32'h0000_2000, 32'd320, 100, 0, 0, to);
    err_idx = -1;
    compared++;
    if (to || wr_mm2s_err !== 1'b1 || datamover_status[3:2] !== 2'b10) begin
      $display("FAIL bresp_status got=%b/%b timeout=%b want=1/10", wr_mm2s_err, datamover_status[3:2], to);
      mismatched++;
    end
    compared++;
    if (datamover_status[1] !== 1'b0 || w_data_q != exp_q) begin
      $display("FAIL bresp_continue got=ovf %b beats %0d want=ovf 0 beats %0d", datamover_status[1],
               w_data_q.size(), exp_q.size());
      mismatched++;
    end
  endtask

  task automatic test_write_reset();
    bit took, to;
    exp_q.delete();
    @(negedge clk);
    start_address = 32'h0000_0800; cap_size = 32'd4096; write_start = 1;
    @(negedge clk);
    write_start = 0;
    for (int i = 0; i < 4; i++) begin
      drive_sample(100, took);
      @(negedge clk);
    end
    tvalid = '0;
    compared++;
    if (datamover_status[0] !== 1'b1) begin $display("FAIL wreset_busy_before got=%b want=1", datamover_status[0]); mismatched++; end
    write_reset = 1;
    @(negedge clk);
    compared++;
    if (datamover_status !== 32'h0 || cap_done !== 1'b0 || wr_mm2s_err !== 1'b0 || current_addr !== 32'h0) begin
      $display("FAIL wreset_cleared got=%h/%b/%b/%h want=0/0/0/0", datamover_status, cap_done, wr_mm2s_err, current_addr);
      mismatched++;
    end
    compared++;
    if (tready !== 6'h00 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
      $display("FAIL wreset_bus got=%h/%b/%b want=00/0/0", tready, awvalid, wvalid); mismatched++;
    end
    write_reset = 0;
    ready_pct = 100;
    run_capture(32'h0000_0040, 32'd320, 100, 0, 0, to);
    compared++;
    if (to || w_data_q != exp_q) begin
      $display("FAIL wreset_flushed got=%0d beats timeout=%b want=%0d beats (or content differs)",
               w_data_q.size(), to, exp_q.size());
      mismatched++;
    end
  endtask

  initial begin
    write_start = 0; write_reset = 0; start_address = '0; cap_size = '0; tvalid = '0;
    for (int k = 0; k < 6; k++) tdata[k] = '0;
    test_reset();
    test_basic();
    test_4k_boundary();
    test_small_cap();
    test_back_to_back();
    test_overflow();
    test_bresp_err();
    test_write_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
